// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: functional-unit IDs, lane-index width and the
// field layout of a decoded-instruction payload.
package decode_pkg;

   localparam int LANE_ID_WIDTH = 3;

   typedef enum logic [2:0] {
      FU_FX     = 3'd0,
      FU_FP     = 3'd1,
      FU_VX     = 3'd2,
      FU_CR     = 3'd3,
      FU_LS     = 3'd4,
      FU_BRANCH = 3'd6
   } fu_type_e;

   // Decoded-instruction layout, LSB first; 200 bits in total.
   localparam int OPC_LSB   = 0;    localparam int OPC_W   = 32;
   localparam int ADDR_LSB  = 32;   localparam int ADDR_W  = 64;
   localparam int FU_LSB    = 96;   localparam int FU_W    = 3;
   localparam int MAJOR_LSB = 99;   localparam int MAJOR_W = 16;
   localparam int MINOR_LSB = 115;  localparam int MINOR_W = 8;
   localparam int PID_LSB   = 123;  localparam int PID_W   = 16;
   localparam int TID_LSB   = 139;  localparam int TID_W   = 8;
   localparam int FLAGS_LSB = 147;  localparam int FLAGS_W = 8;
   localparam int BODY_LSB  = 155;  localparam int BODY_W  = 45;
   localparam int DECODED_WIDTH = BODY_LSB + BODY_W;

endpackage

// File: rtl/decode_arb_fifo.sv
// Synchronous FIFO with flush; a push is accepted while full if a pop happens
// in the same cycle.
module decode_arb_fifo #(
   parameter int Width = 8,
   parameter int Depth = 8,
   localparam int AddrW = $clog2(Depth)
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AddrW:0]   count_o
);

   logic [Depth-1:0][Width-1:0] mem_q;
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AddrW+1)'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/decode_lane_arbiter.sv
// Merges per-lane decoder outputs through one-entry skids and a round-robin
// arbiter into a shared FIFO feeding rename/dispatch.
module decode_lane_arbiter
   import decode_pkg::*;
#(
   parameter int NumLanes     = 4,
   parameter int PayloadWidth = 200,
   parameter int FifoDepth    = 8,
   parameter int LaneIdWidth  = LANE_ID_WIDTH
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic                             flush_i,
   input  logic [NumLanes-1:0]              enable_i,
   input  logic [NumLanes*PayloadWidth-1:0] payload_i,
   output logic [NumLanes-1:0]              stall_o,
   input  logic                             ready_i,
   output logic                             enable_o,
   output logic [PayloadWidth-1:0]          payload_o,
   output logic [LaneIdWidth-1:0]           laneId_o,
   output logic [$clog2(FifoDepth):0]       occupancy_o,
   output logic                             overflow_o
);

   localparam int EntryW = LaneIdWidth + PayloadWidth;

   logic [NumLanes-1:0]                   skid_vld_q, skid_vld_d;
   logic [NumLanes-1:0][PayloadWidth-1:0] skid_data_q, skid_data_d;
   logic [LaneIdWidth-1:0]                rr_ptr_q, rr_ptr_d;
   logic                                  overflow_q, overflow_d;

   logic                   gnt_any;
   logic [LaneIdWidth-1:0] gnt_idx;
   logic                   fifo_full, fifo_empty, push, pop;
   logic [EntryW-1:0]      fifo_din, fifo_dout;

   // First occupied skid at or after rr_ptr, wrapping.
   always_comb begin
      int lane;
      lane    = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NumLanes; i++) begin
         lane = (int'(rr_ptr_q) + i) % NumLanes;
         if (!gnt_any && skid_vld_q[lane]) begin
            gnt_any = 1'b1;
            gnt_idx = LaneIdWidth'(lane);
         end
      end
   end

   // ready_i reaches the grant only through the full-with-pop case.
   assign pop      = !fifo_empty && ready_i && !flush_i;
   assign push     = gnt_any && (!fifo_full || pop) && !flush_i;
   assign fifo_din = {gnt_idx, skid_data_q[gnt_idx]};

   always_comb begin
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      rr_ptr_d    = rr_ptr_q;
      overflow_d  = overflow_q;
      if (flush_i) begin
         skid_vld_d = '0;
         rr_ptr_d   = '0;
      end else begin
         if (push) begin
            skid_vld_d[gnt_idx] = 1'b0;
            rr_ptr_d = (int'(gnt_idx) == NumLanes - 1) ? '0 : gnt_idx + 1'b1;
         end
         for (int n = 0; n < NumLanes; n++) begin
            if (enable_i[n]) begin
               if (skid_vld_q[n]) begin
                  overflow_d = 1'b1;
               end else begin
                  skid_vld_d[n]  = 1'b1;
                  skid_data_d[n] = payload_i[n*PayloadWidth +: PayloadWidth];
               end
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         skid_vld_q <= '0;
         rr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         skid_vld_q <= skid_vld_d;
         rr_ptr_q   <= rr_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clock_i) begin
      skid_data_q <= skid_data_d;
   end

   decode_arb_fifo #(
      .Width (EntryW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push),
      .data_i  (fifo_din),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (occupancy_o)
   );

   // Head is forced to zero when empty so stale entries never show.
   assign {laneId_o, payload_o} = fifo_empty ? '0 : fifo_dout;
   assign enable_o   = !fifo_empty;
   assign stall_o    = skid_vld_q;
   assign overflow_o = overflow_q;

endmodule
